// File: rtl/cam_i2c_pkg.sv
// Shared types and constants for the camera I2C register-write arbiter.
package cam_i2c_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SEND_ADDR,
    SEND_DATA,
    WAIT_DONE
  } state_e;

  localparam int unsigned XFER_BYTES        = 3;
  localparam logic [6:0]  DEV_ADDR_CAM0_DEF = 7'h48;
  localparam logic [6:0]  DEV_ADDR_CAM1_DEF = 7'h5D;

  // Address byte for a write transaction (R/W bit = 0).
  function automatic logic [7:0] addr_wr_byte(input logic [6:0] dev_addr);
    return {dev_addr, 1'b0};
  endfunction

endpackage

// File: rtl/cam_i2c_rr_arbiter.sv
// Two-way round-robin arbiter with a burst lock; grant is one-hot and held
// until the owner's burst completes.
module cam_i2c_rr_arbiter (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       lock_i,
  input  logic       done_i,
  output logic [1:0] grant
);

  logic [1:0] grant_q, grant_d;
  logic       rr_last_q, rr_last_d;

  always_comb begin
    grant_d   = grant_q;
    rr_last_d = rr_last_q;
    if (done_i) begin
      grant_d   = '0;
      rr_last_d = grant_q[1];
    end else if (!lock_i && (|req)) begin
      // Prefer the requester that did not own the bus last time.
      if (rr_last_q) grant_d = req[0] ? 2'b01 : 2'b10;
      else           grant_d = req[1] ? 2'b10 : 2'b01;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grant_q   <= '0;
      rr_last_q <= 1'b1;
    end else begin
      grant_q   <= grant_d;
      rr_last_q <= rr_last_d;
    end
  end

  assign grant = grant_q;

endmodule

// File: rtl/cam_i2c_write_arbiter.sv
// Shares the camera I2C master between two 3-byte register-write streams,
// with NACK retry. Optional stall watchdog enabled by `CAM_I2C_TIMEOUT_EN.
module cam_i2c_write_arbiter
  import cam_i2c_pkg::*;
#(
  parameter logic [6:0]  DEV_ADDR_CAM0  = DEV_ADDR_CAM0_DEF,
  parameter logic [6:0]  DEV_ADDR_CAM1  = DEV_ADDR_CAM1_DEF,
  parameter int unsigned MAX_RETRY      = 3
`ifdef CAM_I2C_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYCLES = 65535
`endif
) (
  input  logic        sysClk,
  input  logic        reset,
  input  logic [1:0]  req_valid,
  input  logic [15:0] req_byte,
  input  logic [1:0]  req_cam_id,
  input  logic [1:0]  req_last,
  output logic [1:0]  req_ready,
  output logic [7:0]  tx_byte,
  output logic        tx_valid,
  output logic        tx_start,
  output logic        tx_stop,
  input  logic        tx_ready,
  input  logic        xfer_done,
  input  logic        xfer_nack,
  output logic [1:0]  grant,
  output logic        busy,
  output logic        err_drop,
  output logic [7:0]  drop_count
);

  state_e     state_q, state_d;
  logic [1:0] byte_idx_q, byte_idx_d;
  logic [1:0] data_idx_q, data_idx_d;
  logic [7:0] xbuf_q [XFER_BYTES];
  logic [7:0] xbuf_d [XFER_BYTES];
  logic       cam_sel_q, cam_sel_d;
  logic       last_seen_q, last_seen_d;
  logic [2:0] retry_cnt_q, retry_cnt_d;
  logic [7:0] drop_count_q, drop_count_d;
  logic       err_drop_q, err_drop_d;
  logic [1:0] req_ready_q, req_ready_d;
  logic [7:0] tx_byte_q, tx_byte_d;
  logic       tx_valid_q, tx_valid_d;
  logic       tx_start_q, tx_start_d;
  logic       tx_stop_q, tx_stop_d;

  logic       g_sel;
  logic [7:0] in_byte;
  logic       in_cam;
  logic       in_last;
  logic       accept;
  logic       nack_evt;
  logic       ok_evt;
  logic       burst_done;
  logic       timeout_hit;

  cam_i2c_rr_arbiter u_arb (
    .clk    (sysClk),
    .rst    (reset),
    .req    (req_valid),
    .lock_i (state_q != IDLE),
    .done_i (burst_done),
    .grant  (grant)
  );

  always_comb begin
    state_d      = state_q;
    byte_idx_d   = byte_idx_q;
    data_idx_d   = data_idx_q;
    xbuf_d       = xbuf_q;
    cam_sel_d    = cam_sel_q;
    last_seen_d  = last_seen_q;
    retry_cnt_d  = retry_cnt_q;
    drop_count_d = drop_count_q;
    err_drop_d   = 1'b0;
    burst_done   = 1'b0;

    g_sel    = grant[1];
    in_byte  = g_sel ? req_byte[15:8] : req_byte[7:0];
    in_cam   = req_cam_id[g_sel];
    in_last  = req_last[g_sel];
    accept   = |(req_valid & req_ready_q);
    nack_evt = timeout_hit || ((state_q == WAIT_DONE) && xfer_done && xfer_nack);
    ok_evt   = (state_q == WAIT_DONE) && xfer_done && !xfer_nack;

    case (state_q)
      IDLE: begin
        if (|req_valid) begin
          state_d     = LOAD;
          byte_idx_d  = '0;
          last_seen_d = 1'b0;
        end
      end
      LOAD: begin
        if (accept) begin
          // A short burst zero-pads the bytes it never delivered.
          for (int unsigned i = 0; i < XFER_BYTES; i++) begin
            if (32'(byte_idx_q) == i)                 xbuf_d[i] = in_byte;
            else if (in_last && (i > 32'(byte_idx_q))) xbuf_d[i] = '0;
          end
          if (byte_idx_q == 2'd0) cam_sel_d = in_cam;
          last_seen_d = in_last;
          byte_idx_d  = byte_idx_q + 2'd1;
          if ((byte_idx_q == 2'd2) || in_last) state_d = SEND_ADDR;
        end
      end
      SEND_ADDR: begin
        if (tx_ready) begin
          state_d    = SEND_DATA;
          data_idx_d = '0;
        end
      end
      SEND_DATA: begin
        if (tx_ready) begin
          if (data_idx_q == 2'd2) state_d = WAIT_DONE;
          else                    data_idx_d = data_idx_q + 2'd1;
        end
      end
      WAIT_DONE: ;
      default:   state_d = IDLE;
    endcase

    // Completion handling; a watchdog expiry can preempt the SEND states.
    if (nack_evt && (32'(retry_cnt_q) < MAX_RETRY)) begin
      retry_cnt_d = retry_cnt_q + 3'd1;
      state_d     = SEND_ADDR;
    end else if (ok_evt || nack_evt) begin
      if (nack_evt) begin
        err_drop_d = 1'b1;
        if (drop_count_q != 8'hFF) drop_count_d = drop_count_q + 8'd1;
      end
      retry_cnt_d = '0;
      if (last_seen_q) begin
        state_d    = IDLE;
        burst_done = 1'b1;
      end else begin
        state_d    = LOAD;
        byte_idx_d = '0;
      end
    end

    req_ready_d = ((state_q == LOAD) && (state_d == LOAD)) ? grant : '0;
    tx_valid_d  = (state_d == SEND_ADDR) || (state_d == SEND_DATA);
    tx_start_d  = (state_d == SEND_ADDR);
    tx_stop_d   = (state_d == SEND_DATA) && (data_idx_d == 2'd2);
    tx_byte_d   = '0;
    if (state_d == SEND_ADDR) begin
      tx_byte_d = addr_wr_byte(cam_sel_d ? DEV_ADDR_CAM1 : DEV_ADDR_CAM0);
    end else if (state_d == SEND_DATA) begin
      for (int unsigned i = 0; i < XFER_BYTES; i++) begin
        if (32'(data_idx_d) == i) tx_byte_d = xbuf_d[i];
      end
    end
  end

`ifdef CAM_I2C_TIMEOUT_EN
  logic [15:0] wd_q, wd_d;
  logic        stall;

  always_comb begin
    stall = (((state_q == SEND_ADDR) || (state_q == SEND_DATA)) && !tx_ready) ||
            ((state_q == WAIT_DONE) && !xfer_done);
    timeout_hit = stall && (32'(wd_q) + 32'd1 >= TIMEOUT_CYCLES);
    wd_d = stall ? wd_q + 16'd1 : '0;
    if (timeout_hit || (state_d != state_q)) wd_d = '0;
  end

  always_ff @(posedge sysClk or posedge reset) begin
    if (reset) wd_q <= '0;
    else       wd_q <= wd_d;
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge sysClk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      byte_idx_q   <= '0;
      data_idx_q   <= '0;
      xbuf_q       <= '{default: '0};
      cam_sel_q    <= 1'b0;
      last_seen_q  <= 1'b0;
      retry_cnt_q  <= '0;
      drop_count_q <= '0;
      err_drop_q   <= 1'b0;
      req_ready_q  <= '0;
      tx_byte_q    <= '0;
      tx_valid_q   <= 1'b0;
      tx_start_q   <= 1'b0;
      tx_stop_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      byte_idx_q   <= byte_idx_d;
      data_idx_q   <= data_idx_d;
      xbuf_q       <= xbuf_d;
      cam_sel_q    <= cam_sel_d;
      last_seen_q  <= last_seen_d;
      retry_cnt_q  <= retry_cnt_d;
      drop_count_q <= drop_count_d;
      err_drop_q   <= err_drop_d;
      req_ready_q  <= req_ready_d;
      tx_byte_q    <= tx_byte_d;
      tx_valid_q   <= tx_valid_d;
      tx_start_q   <= tx_start_d;
      tx_stop_q    <= tx_stop_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign tx_byte    = tx_byte_q;
  assign tx_valid   = tx_valid_q;
  assign tx_start   = tx_start_q;
  assign tx_stop    = tx_stop_q;
  assign busy       = (state_q != IDLE);
  assign err_drop   = err_drop_q;
  assign drop_count = drop_count_q;

endmodule

// File: tb/tb_cam_i2c_write_arbiter.sv
// Directed, table-driven bench for cam_i2c_write_arbiter with a small
// requester/I2C-master model driven on the falling clock edge.
module tb_cam_i2c_write_arbiter;

  logic        sysClk = 1'b0;
  logic        reset  = 1'b0;
  logic [1:0]  req_valid = '0;
  logic [15:0] req_byte = '0;
  logic [1:0]  req_cam_id = '0;
  logic [1:0]  req_last = '0;
  logic [1:0]  req_ready;
  logic [7:0]  tx_byte;
  logic        tx_valid, tx_start, tx_stop;
  logic        tx_ready = 1'b0;
  logic        xfer_done = 1'b0;
  logic        xfer_nack = 1'b0;
  logic [1:0]  grant;
  logic        busy, err_drop;
  logic [7:0]  drop_count;

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

  always #5 sysClk = ~sysClk;

  cam_i2c_write_arbiter #(
    .DEV_ADDR_CAM0 (7'h48),
    .DEV_ADDR_CAM1 (7'h5D),
    .MAX_RETRY     (3)
  ) dut (
    .sysClk     (sysClk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_byte   (req_byte),
    .req_cam_id (req_cam_id),
    .req_last   (req_last),
    .req_ready  (req_ready),
    .tx_byte    (tx_byte),
    .tx_valid   (tx_valid),
    .tx_start   (tx_start),
    .tx_stop    (tx_stop),
    .tx_ready   (tx_ready),
    .xfer_done  (xfer_done),
    .xfer_nack  (xfer_nack),
    .grant      (grant),
    .busy       (busy),
    .err_drop   (err_drop),
    .drop_count (drop_count)
  );

  // Bytes are little-endian in b0/b1; frames are {addr,d0,d1,d2}, frame 0 lowest.
  typedef struct packed {
    logic [3:0]   n0;
    logic [47:0]  b0;
    logic [5:0]   c0;
    logic [3:0]   n1;
    logic [47:0]  b1;
    logic [5:0]   c1;
    logic [2:0]   nacks;
    logic         chk_rdy;
    logic [2:0]   nfr;
    logic [191:0] fr;
    logic [2:0]   ngr;
    logic [7:0]   gexp;
    logic [7:0]   exp_drops;
    logic [7:0]   exp_cnt;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic run_vec(input int unsigned vi);
    vec_t        v;
    int unsigned idx0, idx1, nack_left, cd, scnt, gcnt, drops, rdy_viol, cyc;
    logic        hs0, hs1, in_flight, fin;
    logic [9:0]  st [32];
    logic [1:0]  gs [4];
    logic [1:0]  lastg;
    logic [9:0]  e;
    int unsigned pos;
    v = vecs[vi];
    idx0 = 0; idx1 = 0; nack_left = 32'(v.nacks); cd = 0; scnt = 0; gcnt = 0;
    drops = 0; rdy_viol = 0; cyc = 0; hs0 = 0; hs1 = 0; in_flight = 0; fin = 0;
    lastg = '0;
    for (int k = 0; k < 32; k++) st[k] = '0;
    for (int k = 0; k < 4; k++) gs[k] = '0;
    while (!fin && cyc < 400) begin
      @(negedge sysClk);
      cyc++;
      xfer_done = 1'b0;
      xfer_nack = 1'b0;
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          xfer_done = 1'b1;
          if (nack_left > 0) begin
            xfer_nack = 1'b1;
            nack_left--;
          end else begin
            in_flight = 1'b0;
          end
        end
      end
      if (err_drop) drops++;
      if (in_flight && (|req_ready)) rdy_viol++;
      if ((grant != 2'b00) && (grant != lastg)) begin
        if (gcnt < 4) gs[gcnt] = grant;
        gcnt++;
        lastg = grant;
      end
      if (hs0) idx0++;
      if (hs1) idx1++;
      if (idx0 < 32'(v.n0)) begin
        req_valid[0]    = 1'b1;
        req_byte[7:0]   = v.b0[idx0*8 +: 8];
        req_cam_id[0]   = v.c0[idx0];
        req_last[0]     = (idx0 == 32'(v.n0) - 1);
      end else begin
        req_valid[0] = 1'b0;
        req_last[0]  = 1'b0;
      end
      if (idx1 < 32'(v.n1)) begin
        req_valid[1]    = 1'b1;
        req_byte[15:8]  = v.b1[idx1*8 +: 8];
        req_cam_id[1]   = v.c1[idx1];
        req_last[1]     = (idx1 == 32'(v.n1) - 1);
      end else begin
        req_valid[1] = 1'b0;
        req_last[1]  = 1'b0;
      end
      hs0 = req_valid[0] && req_ready[0];
      hs1 = req_valid[1] && req_ready[1];
      tx_ready = 1'b1;
      if (tx_valid) begin
        if (scnt < 32) st[scnt] = {tx_start, tx_stop, tx_byte};
        scnt++;
        if (tx_start) in_flight = 1'b1;
        if (tx_stop)  cd = 2;
      end
      fin = (idx0 >= 32'(v.n0)) && (idx1 >= 32'(v.n1)) && !busy && (cd == 0) && !xfer_done;
    end
    req_valid = '0;
    req_last  = '0;
    xfer_done = 1'b0;
    xfer_nack = 1'b0;
    chk($sformatf("v%0d_done_in_time", vi), 32'(fin), 32'd1);
    chk($sformatf("v%0d_tx_count", vi), scnt, 32'(v.nfr) * 4);
    for (int unsigned j = 0; j < 32'(v.nfr) * 4 && j < 32; j++) begin
      pos = j % 4;
      e = {pos == 0, pos == 3, v.fr[(j/4)*32 + (3-pos)*8 +: 8]};
      chk($sformatf("v%0d_tx%0d", vi, j), 32'(st[j]), 32'(e));
    end
    chk($sformatf("v%0d_grant_changes", vi), gcnt, 32'(v.ngr));
    for (int unsigned k = 0; k < 32'(v.ngr) && k < 4; k++)
      chk($sformatf("v%0d_grant_seq%0d", vi, k), 32'(gs[k]), 32'(v.gexp[k*2 +: 2]));
    chk($sformatf("v%0d_err_drop_pulses", vi), drops, 32'(v.exp_drops));
    chk($sformatf("v%0d_drop_count", vi), 32'(drop_count), 32'(v.exp_cnt));
    chk($sformatf("v%0d_idle_grant", vi), 32'(grant), 32'd0);
    chk($sformatf("v%0d_idle_busy", vi), 32'(busy), 32'd0);
    if (v.chk_rdy) chk($sformatf("v%0d_ready_during_retry", vi), rdy_viol, 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL global_timeout: got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    int unsigned lat;
    vecs[0] = '{n0:4'd3, b0:48'h332211, c0:6'b000000, n1:4'd3, b1:48'h665544, c1:6'b000111,
                nacks:3'd0, chk_rdy:1'b0, nfr:3'd2,
                fr:{128'h0, 32'hBA445566, 32'h90112233},
                ngr:3'd2, gexp:8'b0000_1001, exp_drops:8'd0, exp_cnt:8'd0};
    vecs[1] = '{n0:4'd6, b0:48'h060504030201, c0:6'b000000, n1:4'd3, b1:48'hA3A2A1, c1:6'b000111,
                nacks:3'd0, chk_rdy:1'b0, nfr:3'd3,
                fr:{96'h0, 32'hBAA1A2A3, 32'h90040506, 32'h90010203},
                ngr:3'd2, gexp:8'b0000_1001, exp_drops:8'd0, exp_cnt:8'd0};
    vecs[2] = '{n0:4'd3, b0:48'h050008, c0:6'b000000, n1:4'd0, b1:48'h0, c1:6'b000000,
                nacks:3'd0, chk_rdy:1'b0, nfr:3'd1,
                fr:{160'h0, 32'h90080005},
                ngr:3'd1, gexp:8'b0000_0001, exp_drops:8'd0, exp_cnt:8'd0};
    vecs[3] = '{n0:4'd0, b0:48'h0, c0:6'b000000, n1:4'd1, b1:48'h7E, c1:6'b000001,
                nacks:3'd0, chk_rdy:1'b0, nfr:3'd1,
                fr:{160'h0, 32'hBA7E0000},
                ngr:3'd1, gexp:8'b0000_0010, exp_drops:8'd0, exp_cnt:8'd0};
    vecs[4] = '{n0:4'd3, b0:48'hC2C1C0, c0:6'b000000, n1:4'd0, b1:48'h0, c1:6'b000000,
                nacks:3'd2, chk_rdy:1'b1, nfr:3'd3,
                fr:{96'h0, 32'h90C0C1C2, 32'h90C0C1C2, 32'h90C0C1C2},
                ngr:3'd1, gexp:8'b0000_0001, exp_drops:8'd0, exp_cnt:8'd0};
    vecs[5] = '{n0:4'd6, b0:48'hE2E1E0D2D1D0, c0:6'b000000, n1:4'd0, b1:48'h0, c1:6'b000000,
                nacks:3'd4, chk_rdy:1'b0, nfr:3'd5,
                fr:{32'h0, 32'h90E0E1E2, 32'h90D0D1D2, 32'h90D0D1D2, 32'h90D0D1D2, 32'h90D0D1D2},
                ngr:3'd1, gexp:8'b0000_0001, exp_drops:8'd1, exp_cnt:8'd1};
    vecs[6] = '{n0:4'd3, b0:48'h030201, c0:6'b000001, n1:4'd0, b1:48'h0, c1:6'b000000,
                nacks:3'd0, chk_rdy:1'b0, nfr:3'd1,
                fr:{160'h0, 32'hBA010203},
                ngr:3'd1, gexp:8'b0000_0001, exp_drops:8'd0, exp_cnt:8'd1};

    #1 reset = 1'b1;
    repeat (3) @(negedge sysClk);
    chk("rst_tx_valid", 32'(tx_valid), 32'd0);
    chk("rst_tx_start_stop", 32'({tx_start, tx_stop}), 32'd0);
    chk("rst_tx_byte", 32'(tx_byte), 32'd0);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_err_drop", 32'(err_drop), 32'd0);
    chk("rst_drop_count", 32'(drop_count), 32'd0);
    reset = 1'b0;
    repeat (2) @(negedge sysClk);

    for (int unsigned i = 0; i < 7; i++) run_vec(i);

    // Latency, stall hold, stray xfer_done and asynchronous reset mid-frame.
    @(negedge sysClk);
    tx_ready   = 1'b0;
    req_valid  = 2'b01;
    req_byte   = 16'h0008;
    req_cam_id = 2'b00;
    req_last   = 2'b00;
    lat = 0;
    do begin
      @(negedge sysClk);
      lat++;
    end while (!req_ready[0] && lat < 10);
    chk("lat_idle_to_req_ready", lat, 32'd2);
    @(negedge sysClk);
    req_byte[7:0] = 8'h00;
    @(negedge sysClk);
    req_byte[7:0] = 8'h05;
    req_last[0]   = 1'b1;
    @(negedge sysClk);
    req_valid = '0;
    req_last  = '0;
    chk("lat_third_byte_tx_valid", 32'(tx_valid), 32'd1);
    chk("addr_tx_start", 32'(tx_start), 32'd1);
    chk("addr_tx_byte", 32'(tx_byte), 32'h90);
    chk("no_fourth_ready", 32'(req_ready), 32'd0);
    tx_ready = 1'b1;
    @(negedge sysClk);
    tx_ready = 1'b0;
    chk("data0_tx_byte", 32'(tx_byte), 32'h08);
    chk("data0_flags", 32'({tx_valid, tx_start, tx_stop}), 32'b100);
    xfer_done = 1'b1;
    @(negedge sysClk);
    xfer_done = 1'b0;
    @(negedge sysClk);
    chk("stall_hold_valid", 32'(tx_valid), 32'd1);
    chk("stall_hold_byte", 32'(tx_byte), 32'h08);
    #2 reset = 1'b1;
    #1;
    chk("async_rst_tx_valid", 32'(tx_valid), 32'd0);
    chk("async_rst_grant", 32'(grant), 32'd0);
    chk("async_rst_busy", 32'(busy), 32'd0);
    chk("async_rst_drop_count", 32'(drop_count), 32'd0);
    @(negedge sysClk);
    reset = 1'b0;
    @(negedge sysClk);
    chk("post_rst_stop", 32'({tx_valid, tx_stop}), 32'd0);

    run_vec(0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/cam_i2c_write_arbiter.md
Name: cam_i2c_write_arbiter

Overview:
- Shares the single camera I2C master between two register-write byte streams: requester 0 (camera-config command path) and requester 1 (boot/recovery init sequencer).
- Collects each 3-byte register write (reg addr, data MSB, data LSB) into a local buffer.
- Frames the write as one I2C transaction to the selected camera's device address, and retries it on NACK.
- Sits between the register-write command tables and the camera I2C bit-level master.

Parameters:
- DEV_ADDR_CAM0, 7'h48, 7-bit I2C address of camera 0
- DEV_ADDR_CAM1, 7'h5D, 7-bit I2C address of camera 1
- MAX_RETRY, 3, NACK retries per transaction before drop (0..7)
- TIMEOUT_CYCLES, 65535, stall limit for the optional watchdog (16-bit)

Ports:
- sysClk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- req_valid  in  2  per-requester byte valid
- req_byte  in  16  {req1_byte, req0_byte}
- req_cam_id  in  2  per-requester target camera (0/1); sampled on the first byte of each transaction
- req_last  in  2  per-requester: byte is the final byte of the burst
- req_ready  out  2  byte accepted when req_valid & req_ready are both high
- tx_byte  out  8  byte to the I2C master
- tx_valid  out  1  tx_byte valid
- tx_start  out  1  qualifies the address byte: generate START before it
- tx_stop  out  1  qualifies the last data byte: generate STOP after it
- tx_ready  in  1  master accepts the byte when tx_valid & tx_ready are both high
- xfer_done  in  1  one-cycle pulse: transaction finished
- xfer_nack  in  1  valid with xfer_done: slave NACKed
- grant  out  2  one-hot current owner; 0 when idle
- busy  out  1  state != IDLE
- err_drop  out  1  one-cycle pulse: transaction dropped after MAX_RETRY
- drop_count  out  8  saturating count of dropped transactions

Behaviour:
- Reset values: all outputs 0; buffer cleared; rr_last = 1 (requester 0 wins first).
- State IDLE:
  - If any req_valid is high, set grant: round-robin, preferring the requester other than rr_last.
  - Go to LOAD next cycle.
  - A burst lock holds the grant until the req_last byte has been sent successfully or dropped. Only then does rr_last update and the state return to IDLE.
- State LOAD:
  - req_ready[g] = 1 while byte_idx < 3; each accepted byte goes to buf[byte_idx] and byte_idx increments.
  - cam_sel latches req_cam_id[g] at byte_idx = 0.
  - last_seen latches req_last[g] on any accepted byte.
  - When byte_idx reaches 3: go to SEND_ADDR and drop req_ready the same cycle (no 4th byte accepted).
  - If req_last arrives before 3 bytes: zero-pad the remaining bytes and proceed.
- State SEND_ADDR:
  - tx_byte = {dev_addr(cam_sel), 1'b0}, tx_valid = 1, tx_start = 1.
  - Hold until tx_ready; then go to SEND_DATA with data_idx = 0.
- State SEND_DATA:
  - tx_byte = buf[data_idx], tx_valid = 1; tx_stop = 1 when data_idx = 2.
  - On each handshake data_idx increments; after index 2, go to WAIT_DONE.
  - tx_* stay stable while tx_ready is low.
- State WAIT_DONE (tx_valid = 0):
  - xfer_done & !xfer_nack: clear retry_cnt. If last_seen, go to IDLE; else go to LOAD (same grant).
  - xfer_done & xfer_nack & retry_cnt < MAX_RETRY: retry_cnt++, resend from the buffer (SEND_ADDR); the requester is not re-read.
  - xfer_done & xfer_nack & retry_cnt = MAX_RETRY: pulse err_drop, drop_count++ (saturates at 255), clear retry_cnt, then continue as on success.
- Ignored inputs:
  - xfer_done outside WAIT_DONE is ignored.
  - req_valid of the non-granted requester is ignored while it is not granted (req_ready held 0).
- Reset mid-transaction: everything returns to reset values immediately; the partial buffer is discarded; no tx_stop is issued (the I2C master handles its own bus recovery).
- Latency:
  - Idle with req_valid to first req_ready: 2 cycles.
  - Third byte accepted to tx_valid on the address byte: 1 cycle.

Optional Feature:
- CAM_I2C_TIMEOUT_EN defined:
  - A 16-bit watchdog counts cycles spent in SEND_ADDR/SEND_DATA without tx_ready, or in WAIT_DONE without xfer_done.
  - At TIMEOUT_CYCLES: treat as NACK (same retry/drop path) and clear the counter.
  - The counter clears on every handshake or state change.
- Undefined: no watchdog; the block waits indefinitely.

Decomposition:
- Shared package cam_i2c_pkg:
  - state enum {IDLE, LOAD, SEND_ADDR, SEND_DATA, WAIT_DONE}
  - XFER_BYTES = 3
  - default camera addresses
- One natural sub-module: cam_i2c_rr_arbiter (2-way round-robin with lock input, rr_last register, one-hot grant).

Test Plan:
- Only req0 valid, bytes 08,00,05 with last, cam_id = 0 -> tx sequence 90(start), 08, 00, 05(stop); after xfer_done, grant returns to 00 and busy = 0.
- req0 and req1 valid in the same cycle from reset -> req0 granted first; after req0's last byte, req1 (cam_id = 1) is sent with address byte BA; grant toggles 01->10.
- req0 two-transaction burst (last on byte 6) with req1 pending -> both req0 transactions complete before req1 gets grant.
- xfer_nack on two consecutive attempts, then ack -> same 4 bytes sent 3 times, req_ready stays low throughout, err_drop never pulses.
- Continuous NACK with MAX_RETRY = 3 -> 4 attempts, err_drop pulses once, drop_count = 1, and the next transaction proceeds.
- Reset asserted mid SEND_DATA with tx_ready held low -> tx_valid and grant are 0 asynchronously; after release, a fresh request starts from LOAD with byte_idx = 0.
